single_to_unsigned_int: RTL and testbench



---
 rtl/single_to_unsigned_int.sv | 165 ++++++++++++++++
 tb/tb_single_to_unsigned_int.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/single_to_unsigned_int.sv
// ============================================================================
// Module      : single_to_unsigned_int
// Description : 3-stage pipelined IEEE-754 single to 32-bit unsigned integer
//               converter, truncating toward zero with saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module single_to_unsigned_int (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic        a_valid,
    output logic        a_ready,
    output logic [31:0] z,
    output logic        z_invalid,
    output logic        z_valid,
    input  logic        z_ready
);

    typedef enum logic [1:0] {
        CLS_NORMAL   = 2'd0,
        CLS_ZERO     = 2'd1,
        CLS_ZERO_INV = 2'd2,
        CLS_MAX_INV  = 2'd3
    } cls_e;

    logic        advance;

    // Stage 1: classification and unpacked significand
    logic        v1_q,    v1_d;
    cls_e        cls1_q,  cls1_d;
    logic [4:0]  sh1_q,   sh1_d;
    logic [23:0] mant1_q, mant1_d;

    // Stage 2: truncated shift result
    logic        v2_q,    v2_d;
    cls_e        cls2_q,  cls2_d;
    logic [31:0] int2_q,  int2_d;

    // Stage 3: saturated output
    logic        z_valid_q,   z_valid_d;
    logic [31:0] z_q,         z_d;
    logic        z_invalid_q, z_invalid_d;

    logic        in_sign;
    logic [7:0]  in_exp;
    logic [22:0] in_man;
    cls_e        in_cls;
    logic [54:0] shift_full;

    assign advance   = !z_valid_q || z_ready;
    assign a_ready   = advance;
    assign z         = z_q;
    assign z_invalid = z_invalid_q;
    assign z_valid   = z_valid_q;

    assign in_sign = a[31];
    assign in_exp  = a[30:23];
    assign in_man  = a[22:0];

    // Order matters: NaN outranks the sign test, and -inf falls into the
    // negative-magnitude-at-least-one bucket.
    always_comb begin
        in_cls = CLS_NORMAL;
        if (in_exp == 8'd255 && in_man != 23'd0) begin
            in_cls = CLS_ZERO_INV;
        end else if (in_exp == 8'd255 && !in_sign) begin
            in_cls = CLS_MAX_INV;
        end else if (in_sign && in_exp >= 8'd127) begin
            in_cls = CLS_ZERO_INV;
        end else if (in_exp < 8'd127) begin
            in_cls = CLS_ZERO;
        end else if (in_exp >= 8'd159) begin
            in_cls = CLS_MAX_INV;
        end
    end

    always_comb begin
        v1_d    = v1_q;
        cls1_d  = cls1_q;
        sh1_d   = sh1_q;
        mant1_d = mant1_q;
        if (advance) begin
            v1_d = a_valid;
            if (a_valid) begin
                cls1_d  = in_cls;
                sh1_d   = 5'(in_exp - 8'd127);
                mant1_d = {1'b1, in_man};
            end
        end
    end

    // Full-width shift keeps every significant bit; the >>23 then truncates.
    assign shift_full = {31'd0, mant1_q} << sh1_q;

    always_comb begin
        v2_d   = v2_q;
        cls2_d = cls2_q;
        int2_d = int2_q;
        if (advance) begin
            v2_d = v1_q;
            if (v1_q) begin
                cls2_d = cls1_q;
                int2_d = 32'(shift_full >> 23);
            end
        end
    end

    always_comb begin
        z_valid_d   = z_valid_q;
        z_d         = z_q;
        z_invalid_d = z_invalid_q;
        if (advance) begin
            z_valid_d = v2_q;
            if (v2_q) begin
                case (cls2_q)
                    CLS_NORMAL: begin
                        z_d         = int2_q;
                        z_invalid_d = 1'b0;
                    end
                    CLS_ZERO: begin
                        z_d         = 32'd0;
                        z_invalid_d = 1'b0;
                    end
                    CLS_ZERO_INV: begin
                        z_d         = 32'd0;
                        z_invalid_d = 1'b1;
                    end
                    default: begin
                        z_d         = 32'hFFFF_FFFF;
                        z_invalid_d = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            z_valid_q   <= 1'b0;
            z_q         <= 32'd0;
            z_invalid_q <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            z_valid_q   <= z_valid_d;
            z_q         <= z_d;
            z_invalid_q <= z_invalid_d;
        end
    end

    always_ff @(posedge clk) begin
        cls1_q  <= cls1_d;
        sh1_q   <= sh1_d;
        mant1_q <= mant1_d;
        cls2_q  <= cls2_d;
        int2_q  <= int2_d;
    end

endmodule

`default_nettype wire

// File: tb/tb_single_to_unsigned_int.sv
// ============================================================================
// Module      : tb_single_to_unsigned_int
// Description : Directed and randomized checks of single_to_unsigned_int.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_single_to_unsigned_int;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a;
    logic        a_valid;
    logic        a_ready;
    logic [31:0] z;
    logic        z_invalid;
    logic        z_valid;
    logic        z_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    single_to_unsigned_int dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .z         (z),
        .z_invalid (z_invalid),
        .z_valid   (z_valid),
        .z_ready   (z_ready)
    );

    // Reference: {z_invalid, z}, shifting a 32-bit significand right or left.
    function automatic logic [32:0] ref_conv(input logic [31:0] x);
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        logic [31:0] sig;
        s   = x[31];
        e   = x[30:23];
        m   = x[22:0];
        sig = {8'd0, 1'b1, m};
        if (e == 8'd255) begin
            if (m != 23'd0) return {1'b1, 32'd0};
            if (s)          return {1'b1, 32'd0};
            return {1'b1, 32'hFFFF_FFFF};
        end
        if (e < 8'd127) return {1'b0, 32'd0};
        if (s)          return {1'b1, 32'd0};
        if (e >= 8'd159) return {1'b1, 32'hFFFF_FFFF};
        if (e <= 8'd150) return {1'b0, sig >> (8'd150 - e)};
        return {1'b0, sig << (e - 8'd150)};
    endfunction

    task automatic test_reset();
        rst_n   = 1'b0;
        a       = 32'd0;
        a_valid = 1'b0;
        z_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({z_valid, z_invalid, z} !== 34'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b inv=%b z=%h exp 0/0/0", z_valid, z_invalid, z);
        end
        rst_n   = 1'b1;
        a       = 32'h3F80_0000;
        a_valid = 1'b1;
        #1;
        checks++;
        if (a_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_a_ready got %b exp 1", a_ready);
        end
        @(negedge clk);
        a_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({z_valid, z_invalid, z} !== {2'b10, 32'd1}) begin
            errors++;
            $display("FAIL first_capture got v=%b inv=%b z=%h exp 1/0/00000001", z_valid, z_invalid, z);
        end
        @(negedge clk);
        checks++;
        if (z_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_capture_drain got z_valid=%b exp 0", z_valid);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [11];
        logic [31:0] ez [11];
        logic        ei [11];
        va = '{32'h3F80_0000, 32'h4049_0FDB, 32'h4B00_0001, 32'h4F7F_FFFF, 32'h4F80_0000,
               32'h7F80_0000, 32'h7FC0_0000, 32'hBF80_0000, 32'hBF00_0000, 32'h8000_0000,
               32'h0000_0001};
        ez = '{32'd1, 32'd3, 32'h0080_0001, 32'hFFFF_FF00, 32'hFFFF_FFFF,
               32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        ei = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        z_ready = 1'b1;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            checks++;
            if (j >= 3 && j < 14) begin
                if ({z_valid, z_invalid, z} !== {1'b1, ei[j-3], ez[j-3]}) begin
                    errors++;
                    $display("FAIL directed_%0d a=%h got v=%b inv=%b z=%h exp v=1 inv=%b z=%h",
                             j - 3, va[j-3], z_valid, z_invalid, z, ei[j-3], ez[j-3]);
                end
            end else if (z_valid !== 1'b0) begin
                errors++;
                $display("FAIL directed_latency cycle %0d got z_valid=%b exp 0", j, z_valid);
            end
            if (j < 11) begin
                a       = va[j];
                a_valid = 1'b1;
            end else begin
                a_valid = 1'b0;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] vb [10];
        int          tx      = 0;
        int          rx      = 0;
        logic        stalled = 1'b0;
        logic [33:0] held    = '0;
        vb = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000,
               32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000, 32'h4110_0000, 32'h4120_0000};
        for (int cyc = 0; cyc < 300 && rx < 10; cyc++) begin
            @(negedge clk);
            if (stalled) begin
                checks++;
                if ({z_valid, z_invalid, z} !== held) begin
                    errors++;
                    $display("FAIL bp_stable got v=%b inv=%b z=%h exp %h", z_valid, z_invalid, z, held);
                end
            end
            z_ready = 1'($urandom_range(0, 1));
            a_valid = (tx < 10);
            a       = (tx < 10) ? vb[tx] : 32'd0;
            #1;
            checks++;
            if (a_ready !== !(z_valid && !z_ready)) begin
                errors++;
                $display("FAIL bp_a_ready got %b exp %b", a_ready, !(z_valid && !z_ready));
            end
            if (a_valid && a_ready) tx++;
            stalled = z_valid && !z_ready;
            held    = {z_valid, z_invalid, z};
            if (z_valid && z_ready) begin
                checks++;
                if (z !== 32'(rx + 1) || z_invalid !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_result_%0d got z=%h inv=%b exp z=%h inv=0", rx, z, z_invalid, 32'(rx + 1));
                end
                rx++;
            end
        end
        checks++;
        if (rx != 10) begin
            errors++;
            $display("FAIL bp_timeout got %0d results exp 10", rx);
        end
        a_valid = 1'b0;
        z_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (z_valid !== 1'b0) begin
                errors++;
                $display("FAIL bp_duplicate got z_valid=%b z=%h exp z_valid=0", z_valid, z);
            end
        end
    endtask

    task automatic test_reset_midstream();
        z_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a       = 32'h4000_0000 + (32'(k) << 20);
            a_valid = 1'b1;
        end
        @(negedge clk);
        a_valid = 1'b0;
        #1;
        checks++;
        if (z_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_inflight got z_valid=%b exp 1", z_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({z_valid, z_invalid, z} !== 34'd0) begin
            errors++;
            $display("FAIL rst_mid_async got v=%b inv=%b z=%h exp 0/0/0", z_valid, z_invalid, z);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (z_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_stale got z_valid=%b z=%h exp z_valid=0", z_valid, z);
            end
        end
        a       = 32'h4120_0000;
        a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({z_valid, z_invalid, z} !== {2'b10, 32'd10}) begin
            errors++;
            $display("FAIL rst_mid_next got v=%b inv=%b z=%h exp 1/0/0000000a", z_valid, z_invalid, z);
        end
    endtask

    task automatic test_random();
        logic [32:0] q [$];
        logic [31:0] r;
        logic [32:0] e;
        int          shown = 0;
        z_ready = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 50003; j++) begin
            if (j >= 3) begin
                e = q.pop_front();
                checks++;
                if ({z_valid, z_invalid, z} !== {1'b1, e}) begin
                    errors++;
                    if (shown < 10) begin
                        shown++;
                        $display("FAIL random_%0d got v=%b inv=%b z=%h exp v=1 inv=%b z=%h",
                                 j - 3, z_valid, z_invalid, z, e[32], e[31:0]);
                    end
                end
            end
            if (j < 50000) begin
                r = $urandom;
                if (j % 2 == 1) r[30:23] = 8'($urandom_range(118, 165));
                a       = r;
                a_valid = 1'b1;
                q.push_back(ref_conv(r));
            end else begin
                a_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
